// File: rtl/br_pred_pkg.sv
// Shared types for the branch update queue: queued entry layout, FSM states and redirect helper.
package br_pred_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        jump;
  } br_update_t;

  typedef enum logic {
    UPDQ_IDLE  = 1'b0,
    UPDQ_FLUSH = 1'b1
  } updq_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  // Correct fetch PC once the predictor has disagreed with the resolved outcome.
  function automatic logic [31:0] redirect_target(br_update_t e);
    return e.taken ? e.target : e.pc + PC_INC;
  endfunction

endpackage

// File: rtl/br_update_queue_if.sv
// Commit-side, predictor-side and redirect signals of br_update_queue.
// Optional stats ports exist only when BR_UPDQ_STATS_EN is defined.
interface br_update_queue_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_pc;
  logic [31:0]      enq_target;
  logic             enq_taken;
  logic             enq_jump;
  logic             check;
  logic [31:0]      pc_curr_update;
  logic [31:0]      pc_out_br_bus;
  logic             was_taken_not_taken;
  logic             was_jump;
  logic             mispredicted;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_in;
  logic [PTR_W:0]   count;
`ifdef BR_UPDQ_STATS_EN
  logic [31:0]      stat_checks;
  logic [31:0]      stat_mispredicts;
`endif

  modport slave (
`ifdef BR_UPDQ_STATS_EN
    output stat_checks, output stat_mispredicts,
`endif
    input  enq_valid, enq_pc, enq_target, enq_taken, enq_jump, mispredicted, flush_in,
    output enq_ready, check, pc_curr_update, pc_out_br_bus, was_taken_not_taken, was_jump,
    output redirect_valid, redirect_pc, count
  );

  modport master (
`ifdef BR_UPDQ_STATS_EN
    input  stat_checks, input stat_mispredicts,
`endif
    output enq_valid, enq_pc, enq_target, enq_taken, enq_jump, mispredicted, flush_in,
    input  enq_ready, check, pc_curr_update, pc_out_br_bus, was_taken_not_taken, was_jump,
    input  redirect_valid, redirect_pc, count
  );

endinterface

// File: rtl/br_updq_fifo.sv
// Circular buffer of br_update_t with push/pop/clear; head entry reads as zero when empty.
module br_updq_fifo
  import br_pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  br_update_t      i_data,
  output br_update_t      o_head,
  output logic [PTR_W:0]  o_count
);

  br_update_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = (r_count != '0) ? r_mem[r_head] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/br_update_queue.sv
// Drains committed branch outcomes into the predictor and issues a fetch redirect on mispredict.
// Define BR_UPDQ_STATS_EN to add saturating check/mispredict counters.
module br_update_queue
  import br_pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  br_update_queue_if.slave    bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  updq_state_e    r_state;
  logic           r_redirect_valid;
  logic [31:0]    r_redirect_pc;
  br_update_t     w_head;
  br_update_t     w_enq_data;
  logic [PTR_W:0] w_count;
  logic           w_check;
  logic           w_enq_ready;
  logic           w_mispredict;
  logic           w_push;
  logic           w_clear;

  assign w_check      = (w_count != '0) && (r_state == UPDQ_IDLE);
  assign w_enq_ready  = (w_count < FULL_CNT) && (r_state == UPDQ_IDLE) && !bus.flush_in;
  assign w_mispredict = w_check && bus.mispredicted;
  // A same-cycle enq is younger than the mispredicted head, so it is dropped too.
  assign w_push       = bus.enq_valid && w_enq_ready && !w_mispredict;
  assign w_clear      = bus.flush_in || w_mispredict;
  assign w_enq_data   = '{pc: bus.enq_pc, target: bus.enq_target,
                          taken: bus.enq_taken, jump: bus.enq_jump};

  br_updq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_check),
    .i_clear (w_clear),
    .i_data  (w_enq_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= UPDQ_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (bus.flush_in) begin
      r_state          <= UPDQ_IDLE;
      r_redirect_valid <= 1'b0;
    end else begin
      case (r_state)
        UPDQ_IDLE: begin
          r_redirect_valid <= w_mispredict;
          if (w_mispredict) begin
            r_state       <= UPDQ_FLUSH;
            r_redirect_pc <= redirect_target(w_head);
          end
        end
        default: begin
          r_state          <= UPDQ_IDLE;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_UPDQ_STATS_EN
  logic [31:0] r_stat_checks;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_checks      <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_check && (r_stat_checks != '1))           r_stat_checks      <= r_stat_checks + 1'b1;
      if (w_mispredict && (r_stat_mispredicts != '1)) r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
    end
  end

  assign bus.stat_checks      = r_stat_checks;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

  assign bus.enq_ready           = w_enq_ready;
  assign bus.check               = w_check;
  assign bus.pc_curr_update      = w_head.pc;
  assign bus.pc_out_br_bus       = w_head.target;
  assign bus.was_taken_not_taken = w_head.taken;
  assign bus.was_jump            = w_head.jump;
  assign bus.count               = w_count;
  assign bus.redirect_valid      = r_redirect_valid;
  assign bus.redirect_pc         = r_redirect_pc;

endmodule
